and_gate_reg: RTL and testbench



---
 rtl/and_gate_reg_if.sv | 36 +++
 rtl/and_gate_reg.sv | 60 ++++++
 tb/tb_and_gate_reg.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/and_gate_reg_if.sv
// Operand/result bundle for and_gate_reg.
// The y_ones popcount signal exists only when AND_GATE_POPCOUNT_EN is defined.
interface and_gate_reg_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_any;

`ifdef AND_GATE_POPCOUNT_EN
  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  logic [CW-1:0] y_ones;

  modport master (
    output in_valid, a, b,
    input  out_valid, y, y_all, y_any, y_ones
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, y, y_all, y_any, y_ones
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, y, y_all, y_any
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, y, y_all, y_any
  );
`endif
endinterface

// File: rtl/and_gate_reg.sv
// Registered bitwise AND with all-ones / any-one reduction flags, one cycle latency.
// Optional registered popcount of a & b on y_ones when AND_GATE_POPCOUNT_EN is defined.
module and_gate_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  and_gate_reg_if.slave  bus
);

  logic [WIDTH-1:0] prod;

  assign prod = bus.a & bus.b;

  // Operands are only looked at when in_valid is high, so X on a/b while idle cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.y         <= RESET_VAL;
      bus.y_all     <= &RESET_VAL;
      bus.y_any     <= |RESET_VAL;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.y     <= prod;
        bus.y_all <= &prod;
        bus.y_any <= |prod;
      end
    end
  end

`ifdef AND_GATE_POPCOUNT_EN
  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  localparam logic [CW-1:0] ONES_RESET = popcount(RESET_VAL);

  logic [CW-1:0] prod_ones;

  assign prod_ones = popcount(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y_ones <= ONES_RESET;
    end else if (bus.in_valid) begin
      bus.y_ones <= prod_ones;
    end
  end
`endif

endmodule

// File: tb/tb_and_gate_reg.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against a bit-counting reference model.
module tb_and_gate_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  and_gate_reg_if #(.WIDTH(1)) if1 ();
  and_gate_reg_if #(.WIDTH(8)) if8 ();

  and_gate_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  and_gate_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       exp_ov8;
  logic [7:0] exp_y8;
  logic       exp_all8;
  logic       exp_any8;
  int         exp_ones8;

  task automatic model8_reset();
    exp_ov8   = 1'b0;
    exp_y8    = 8'h00;
    exp_all8  = 1'b0;
    exp_any8  = 1'b0;
    exp_ones8 = 0;
  endtask

  // Reference: count coincident ones; the flags follow from the count.
  task automatic model8(input logic v, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    exp_ov8 = v;
    if (v) begin
      for (int i = 0; i < 8; i++) begin
        exp_y8[i] = (a[i] == 1'b1) && (b[i] == 1'b1);
        if (exp_y8[i]) n++;
      end
      exp_ones8 = n;
      exp_all8  = (n == 8);
      exp_any8  = (n > 0);
    end
  endtask

  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if8.in_valid = v;
    if8.a        = a;
    if8.b        = b;
    @(posedge clk);
    #1;
    model8(v, a, b);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0;
    #1 rst_n = 1'b0;
    #1;
    model8_reset();
    checks++;
    if ({if8.out_valid, if8.y_all, if8.y_any, if8.y} !== {exp_ov8, exp_all8, exp_any8, exp_y8}) begin
      errors++;
      $display("FAIL reset_w8: got ov=%b all=%b any=%b y=%h want ov=%b all=%b any=%b y=%h",
               if8.out_valid, if8.y_all, if8.y_any, if8.y, exp_ov8, exp_all8, exp_any8, exp_y8);
    end
    checks++;
    if ({if1.out_valid, if1.y_all, if1.y_any, if1.y} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w1: got ov/all/any/y=%b%b%b%b want 0000",
               if1.out_valid, if1.y_all, if1.y_any, if1.y);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic ea;
    logic eb;
    logic ey;
    for (int k = 0; k < 4; k++) begin
      ea = (k >= 2);
      eb = (k % 2 == 1);
      ey = ea && eb;
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.a        = ea;
      if1.b        = eb;
      @(posedge clk);
      #1;
      checks++;
      if ({if1.out_valid, if1.y_all, if1.y_any, if1.y} !== {1'b1, ey, ey, ey}) begin
        errors++;
        $display("FAIL truth_%0d%0d: got ov/all/any/y=%b%b%b%b want 1%b%b%b",
                 ea, eb, if1.out_valid, if1.y_all, if1.y_any, if1.y, ey, ey, ey);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0; if1.a = 1'bx; if1.b = 1'bx;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({if1.out_valid, if1.y_all, if1.y_any, if1.y} !== 4'b0111) begin
        errors++;
        $display("FAIL hold_%0d: got ov/all/any/y=%b%b%b%b want 0111",
                 k, if1.out_valid, if1.y_all, if1.y_any, if1.y);
      end
      if (k == 1) begin
        @(negedge clk);
        if1.a = 1'b0; if1.b = 1'b0;
      end
    end
  endtask

  task automatic test_w8_directed();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    va[0] = 8'hFF; vb[0] = 8'hFF;
    va[1] = 8'hF0; vb[1] = 8'h3C;
    va[2] = 8'hAA; vb[2] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      step8(1'b1, va[k], vb[k]);
      checks++;
      if ({if8.out_valid, if8.y_all, if8.y_any, if8.y} !== {exp_ov8, exp_all8, exp_any8, exp_y8}) begin
        errors++;
        $display("FAIL w8_%h_%h: got ov=%b all=%b any=%b y=%h want ov=%b all=%b any=%b y=%h",
                 va[k], vb[k], if8.out_valid, if8.y_all, if8.y_any, if8.y,
                 exp_ov8, exp_all8, exp_any8, exp_y8);
      end
`ifdef AND_GATE_POPCOUNT_EN
      checks++;
      if (int'(if8.y_ones) !== exp_ones8) begin
        errors++;
        $display("FAIL popcount_%h_%h: got %0d want %0d", va[k], vb[k], if8.y_ones, exp_ones8);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if (!v && ($urandom_range(0, 1) == 1)) begin
        a = 8'hxx; b = 8'hxx;
      end
      step8(v, a, b);
      checks++;
      if ({if8.out_valid, if8.y_all, if8.y_any, if8.y} !== {exp_ov8, exp_all8, exp_any8, exp_y8}) begin
        errors++;
        $display("FAIL random_%0d: got ov=%b all=%b any=%b y=%h want ov=%b all=%b any=%b y=%h",
                 k, if8.out_valid, if8.y_all, if8.y_any, if8.y,
                 exp_ov8, exp_all8, exp_any8, exp_y8);
      end
`ifdef AND_GATE_POPCOUNT_EN
      checks++;
      if (int'(if8.y_ones) !== exp_ones8) begin
        errors++;
        $display("FAIL random_ones_%0d: got %0d want %0d", k, if8.y_ones, exp_ones8);
      end
`endif
    end
  endtask

  task automatic test_midstream_reset();
    for (int k = 0; k < 3; k++) begin
      step8(1'b1, 8'hFF, 8'($urandom) | 8'h01);
    end
    @(negedge clk);
    if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
    #1 rst_n = 1'b0;
    if8.in_valid = 1'b0;
    #1;
    model8_reset();
    checks++;
    if ({if8.out_valid, if8.y_all, if8.y_any, if8.y} !== {exp_ov8, exp_all8, exp_any8, exp_y8}) begin
      errors++;
      $display("FAIL midreset_async: got ov=%b all=%b any=%b y=%h want all zero",
               if8.out_valid, if8.y_all, if8.y_any, if8.y);
    end
`ifdef AND_GATE_POPCOUNT_EN
    checks++;
    if (int'(if8.y_ones) !== 0) begin
      errors++;
      $display("FAIL midreset_ones: got %0d want 0", if8.y_ones);
    end
`endif
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model8(1'b0, 8'h00, 8'h00);
    checks++;
    if ({if8.out_valid, if8.y} !== {exp_ov8, exp_y8}) begin
      errors++;
      $display("FAIL midreset_idle: got ov=%b y=%h want ov=%b y=%h",
               if8.out_valid, if8.y, exp_ov8, exp_y8);
    end
    step8(1'b1, 8'hF0, 8'h3C);
    checks++;
    if ({if8.out_valid, if8.y_all, if8.y_any, if8.y} !== {exp_ov8, exp_all8, exp_any8, exp_y8}) begin
      errors++;
      $display("FAIL midreset_resume: got ov=%b all=%b any=%b y=%h want ov=%b all=%b any=%b y=%h",
               if8.out_valid, if8.y_all, if8.y_any, if8.y, exp_ov8, exp_all8, exp_any8, exp_y8);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model8_reset();
    test_reset();
    test_truth_table();
    test_hold();
    test_w8_directed();
    test_random();
    test_midstream_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
